// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: open-drain I2C pin bundle between the initiator side and the target
interface i2c_target_regs_if;
  logic scl_in;
  logic sda_in;
  logic sda_t;
  modport master (output scl_in, output sda_in, input sda_t);
  modport slave (input scl_in, input sda_in, output sda_t);
endinterface

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with address match, ACK generation and auto-incrementing byte register bank
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int NREGS = 4,
  parameter logic [7:0] RESET_VAL0 = 8'h00,
  localparam int PW = $clog2(NREGS)
) (
  input  logic clock,
  input  logic reset,
  i2c_target_regs_if.slave bus,
  output logic [7:0] reg0,
  output logic wr_strobe,
  output logic [PW-1:0] wr_index,
  output logic busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IDLE_WAIT} state_t;
  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
  state_t state_q, state_d;
  logic [3:0] scl_pipe_q, scl_pipe_d, sda_pipe_q, sda_pipe_d;
  logic scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_p_q, sda_p_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc, wr_index_q, wr_index_d;
  logic ph_q, ph_d, rw_q, rw_d, sda_t_q, sda_t_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0] bank_q [NREGS];
  logic [7:0] bank_d [NREGS];
  logic scl_rise, scl_fall, start, stop;
  logic [7:0] byte_in;
  assign scl_pipe_d = {scl_pipe_q[2:0], bus.scl_in};
  assign sda_pipe_d = {sda_pipe_q[2:0], bus.sda_in};
  assign scl_f_d = maj(scl_pipe_q[3:1]);
  assign sda_f_d = maj(sda_pipe_q[3:1]);
  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign byte_in = {sh_q[6:0], sda_f_q};
  assign ptr_inc = (ptr_q == PW'(NREGS - 1)) ? '0 : ptr_q + PW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    ptr_d = ptr_q;
    ph_d = ph_q;
    rw_d = rw_q;
    sda_t_d = sda_t_q;
    busy_d = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d = wr_index_q;
    bank_d = bank_q;
    if (start) begin
      state_d = ADDR;
      cnt_d = 3'd7;
      busy_d = 1'b1;
      sda_t_d = 1'b1;
      ph_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      busy_d = 1'b0;
      sda_t_d = 1'b1;
    end else if (scl_rise) begin
      sh_d = byte_in;
      cnt_d = cnt_q - 3'd1;
      case (state_q)
        ADDR: if (cnt_q == 3'd0) begin
          state_d = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : IDLE;
          busy_d = byte_in[7:1] == TARGET_ADDR;
          rw_d = byte_in[0];
        end
        PTR: if (cnt_q == 3'd0) begin
          ptr_d = byte_in[PW-1:0];
          state_d = PTR_ACK;
        end
        WDATA: if (cnt_q == 3'd0) begin
          bank_d[ptr_q] = byte_in;
          wr_strobe_d = 1'b1;
          wr_index_d = ptr_q;
          ptr_d = ptr_inc;
          state_d = WDATA_ACK;
        end
        RDATA: if (cnt_q == 3'd0) begin
          ptr_d = ptr_inc;
          state_d = RDATA_ACK;
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK: ph_d = 1'b1;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (!ph_q) sda_t_d = 1'b0;
        else begin
          ph_d = 1'b0;
          cnt_d = 3'd7;
          state_d = (state_q != ADDR_ACK) ? WDATA : rw_q ? RDATA : PTR;
          sh_d = bank_q[ptr_q];
          sda_t_d = (state_q == ADDR_ACK && rw_q) ? bank_q[ptr_q][7] : 1'b1;
        end
        RDATA: sda_t_d = sh_q[7];
        RDATA_ACK: if (!ph_q) sda_t_d = 1'b1;
        else begin
          ph_d = 1'b0;
          cnt_d = 3'd7;
          state_d = sh_q[0] ? IDLE_WAIT : RDATA;
          sh_d = bank_q[ptr_q];
          sda_t_d = sh_q[0] | bank_q[ptr_q][7];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      scl_pipe_q <= '1;
      sda_pipe_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
      cnt_q <= 3'd7;
      sh_q <= '0;
      ptr_q <= '0;
      ph_q <= 1'b0;
      rw_q <= 1'b0;
      sda_t_q <= 1'b1;
      busy_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q <= '0;
      for (int i = 0; i < NREGS; i++) bank_q[i] <= (i == 0) ? RESET_VAL0 : 8'h00;
    end else begin
      state_q <= state_d;
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      scl_f_q <= scl_f_d;
      sda_f_q <= sda_f_d;
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ptr_q <= ptr_d;
      ph_q <= ph_d;
      rw_q <= rw_d;
      sda_t_q <= sda_t_d;
      busy_q <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q <= wr_index_d;
      bank_q <= bank_d;
    end
  end
  assign bus.sda_t = sda_t_q;
  assign reg0 = bank_q[0];
  assign wr_strobe = wr_strobe_q;
  assign wr_index = wr_index_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C initiator exercising writes, reads, wrap, mismatch, aborted byte and reset
module tb_i2c_target_regs;
  localparam int Q = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [7:0] reg0;
  logic wr_strobe;
  logic [1:0] wr_index;
  logic busy;
  int passes = 0;
  int total = 0;
  int strobes = 0;
  logic [1:0] idx_q[$];
  logic watch = 1'b0;
  logic saw_low = 1'b0;
  i2c_target_regs_if bus();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & bus.sda_t;
  i2c_target_regs dut (
    .clock(clk),
    .reset(rst),
    .bus(bus),
    .reg0(reg0),
    .wr_strobe(wr_strobe),
    .wr_index(wr_index),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobes++;
      idx_q.push_back(wr_index);
    end
    if (watch && !bus.sda_t) saw_low = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask
  task automatic bit_io(input logic b, output logic o);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    o = bus.sda_in;
    wq();
    scl_m = 1'b0;
    wq();
  endtask
  task automatic i2c_start();
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
    wq();
  endtask
  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic o;
    for (int i = 7; i >= 0; i--) bit_io(b[i], o);
    bit_io(1'b1, ack);
  endtask
  task automatic rbyte(input logic ackb, output logic [7:0] d);
    logic o;
    for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i]);
    bit_io(ackb, o);
  endtask
  initial begin
    logic a;
    logic [7:0] d;
    logic o;
    int s0;
    repeat (4) @(negedge clk);
    chk("rst_sda_t", bus.sda_t, 1);
    chk("rst_reg0", reg0, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_index", wr_index, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    i2c_start();
    chk("t1_busy_on", busy, 1);
    wbyte(8'h84, a);
    chk("t1_ack_addr", a, 0);
    wbyte(8'h00, a);
    chk("t1_ack_ptr", a, 0);
    wbyte(8'hA5, a);
    chk("t1_ack_data", a, 0);
    i2c_stop();
    chk("t1_busy_off", busy, 0);
    chk("t1_reg0", reg0, 8'hA5);
    chk("t1_strobes", strobes, 1);
    chk("t1_index", idx_q.pop_front(), 0);
    i2c_start();
    wbyte(8'h86, a);
    chk("t2_nack_addr", a, 1);
    chk("t2_busy_off", busy, 0);
    wbyte(8'h00, a);
    chk("t2_nack_data", a, 1);
    i2c_stop();
    chk("t2_reg0", reg0, 8'hA5);
    chk("t2_strobes", strobes, 1);
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h03, a);
    wbyte(8'h11, a);
    chk("t3_ack_d0", a, 0);
    wbyte(8'h22, a);
    chk("t3_ack_d1", a, 0);
    i2c_stop();
    chk("t3_strobes", strobes, 3);
    chk("t3_index0", idx_q.pop_front(), 3);
    chk("t3_index1", idx_q.pop_front(), 0);
    chk("t3_reg0_wrap", reg0, 8'h22);
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h01, a);
    wbyte(8'h5A, a);
    wbyte(8'hC3, a);
    i2c_stop();
    chk("t4_strobes", strobes, 5);
    void'(idx_q.pop_front());
    void'(idx_q.pop_front());
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h01, a);
    i2c_start();
    wbyte(8'h85, a);
    chk("t4_ack_raddr", a, 0);
    rbyte(1'b0, d);
    chk("t4_rd0", d, 8'h5A);
    rbyte(1'b1, d);
    chk("t4_rd1", d, 8'hC3);
    chk("t4_released", bus.sda_t, 1);
    bit_io(1'b1, o);
    chk("t4_idle_wait", o, 1);
    chk("t4_busy_held", busy, 1);
    i2c_stop();
    chk("t4_busy_off", busy, 0);
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h03, a);
    i2c_start();
    wbyte(8'h85, a);
    rbyte(1'b1, d);
    i2c_stop();
    chk("t4_rd_reg3", d, 8'h11);
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h00, a);
    for (int i = 0; i < 4; i++) bit_io(1'b1, o);
    i2c_stop();
    chk("t5_strobes", strobes, 5);
    chk("t5_reg0_kept", reg0, 8'h22);
    chk("t5_busy_off", busy, 0);
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h00, a);
    wbyte(8'h3C, a);
    chk("t5_ack_next", a, 0);
    i2c_stop();
    chk("t5_reg0_next", reg0, 8'h3C);
    chk("t5_strobes_next", strobes, 6);
    chk("t5_index_next", idx_q.pop_front(), 0);
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h01, a);
    i2c_start();
    wbyte(8'h85, a);
    chk("t6_driving", bus.sda_t, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_sda_t_rst", bus.sda_t, 1);
    chk("t6_reg0_rst", reg0, 8'h00);
    chk("t6_busy_rst", busy, 0);
    rst = 1'b0;
    s0 = strobes;
    watch = 1'b1;
    for (int i = 0; i < 18; i++) bit_io(i[0], o);
    watch = 1'b0;
    chk("t6_ignored_sda", saw_low, 0);
    chk("t6_ignored_busy", busy, 0);
    chk("t6_ignored_strobe", strobes, s0);
    i2c_stop();
    i2c_start();
    wbyte(8'h84, a);
    chk("t6_ack_after", a, 0);
    wbyte(8'h00, a);
    wbyte(8'h99, a);
    i2c_stop();
    chk("t6_reg0_after", reg0, 8'h99);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
